// File: rtl/dsp_mavg_pkg.sv
// Shared types and sizing helpers for the moving-average stream stage.
package dsp_mavg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_WRITE
    } state_t;

    localparam int DEF_DATA_W        = 8;
    localparam int DEF_LOG2_MAX_TAPS = 3;

    function automatic int max_taps(input int log2_max_taps);
        return 1 << log2_max_taps;
    endfunction

    // Running sum holds up to 2^L full-scale samples without overflow.
    function automatic int sum_width(input int data_w, input int log2_max_taps);
        return data_w + log2_max_taps;
    endfunction

    localparam int DEF_SUM_W = sum_width(DEF_DATA_W, DEF_LOG2_MAX_TAPS);

    function automatic int clamp_tap(input int tap_log2, input int log2_max_taps);
        return (tap_log2 > log2_max_taps) ? log2_max_taps : tap_log2;
    endfunction

endpackage

// File: rtl/dsp_mavg_window.sv
// Circular sample history with running sum and fill counter for a 2^k-tap window.
module dsp_mavg_window
    import dsp_mavg_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int LOG2_MAX_TAPS = 3,
    parameter int TAPSEL_W      = $clog2(LOG2_MAX_TAPS + 1)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          push,
    input  logic                                          clear,
    input  logic [DATA_W-1:0]                             sample,
    input  logic [TAPSEL_W-1:0]                           tap_log2,
    output logic [sum_width(DATA_W, LOG2_MAX_TAPS)-1:0]   sum_next,
    output logic                                          warm
);

    localparam int DEPTH = max_taps(LOG2_MAX_TAPS);
    localparam int SUM_W = sum_width(DATA_W, LOG2_MAX_TAPS);

    logic [DATA_W-1:0]        hist_q [DEPTH];
    logic [DATA_W-1:0]        hist_d [DEPTH];
    logic [LOG2_MAX_TAPS-1:0] ptr_q, ptr_d;
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic [LOG2_MAX_TAPS:0]   fill_q, fill_d;
    logic [LOG2_MAX_TAPS:0]   n_taps;
    logic [LOG2_MAX_TAPS-1:0] old_idx;

    // With N == DEPTH the truncated offset is 0, so the oldest entry is the one being overwritten.
    assign n_taps   = (LOG2_MAX_TAPS + 1)'(1) << tap_log2;
    assign old_idx  = ptr_q - n_taps[LOG2_MAX_TAPS-1:0];
    assign sum_next = sum_q + SUM_W'(sample) - SUM_W'(hist_q[old_idx]);
    assign warm     = (fill_q >= n_taps);

    always_comb begin
        hist_d = hist_q;
        ptr_d  = ptr_q;
        sum_d  = sum_q;
        fill_d = fill_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_d[i] = '0;
            end
            ptr_d  = '0;
            sum_d  = '0;
            fill_d = '0;
        end else if (push) begin
            hist_d[ptr_q] = sample;
            ptr_d         = ptr_q + LOG2_MAX_TAPS'(1);
            sum_d         = sum_next;
            if (fill_q != (LOG2_MAX_TAPS + 1)'(DEPTH)) begin
                fill_d = fill_q + (LOG2_MAX_TAPS + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            ptr_q  <= '0;
            sum_q  <= '0;
            fill_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
            ptr_q  <= ptr_d;
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/dsp_mavg_stream.sv
// Handshake-paced moving-average stage: pops an FWFT input FIFO, averages, pushes to an output FIFO.
module dsp_mavg_stream
    import dsp_mavg_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int LOG2_MAX_TAPS = 3,
    parameter int CNT_W         = 16,
    parameter int TAPSEL_W      = $clog2(LOG2_MAX_TAPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                bypass,
    input  logic                flush,
    input  logic [TAPSEL_W-1:0] tap_log2,
    input  logic                in_empty,
    input  logic [DATA_W-1:0]   in_rd_data,
    output logic                in_rd_inc,
    input  logic                out_full,
    output logic [DATA_W-1:0]   out_w_data,
    output logic                out_w_inc,
    output logic                busy,
    output logic                stall,
    output logic                warm,
    output logic [CNT_W-1:0]    out_count
);

    localparam int SUM_W = sum_width(DATA_W, LOG2_MAX_TAPS);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [TAPSEL_W-1:0] tap_q, tap_d;
    logic                ready_q, ready_d;
    logic [TAPSEL_W-1:0] tap_eff;
    logic                win_push;
    logic                win_clear;
    logic [SUM_W-1:0]    sum_next;

    assign tap_eff = TAPSEL_W'(clamp_tap(int'(tap_log2), LOG2_MAX_TAPS));

    dsp_mavg_window #(
        .DATA_W        (DATA_W),
        .LOG2_MAX_TAPS (LOG2_MAX_TAPS),
        .TAPSEL_W      (TAPSEL_W)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .push     (win_push),
        .clear    (win_clear),
        .sample   (sample_q),
        .tap_log2 (tap_q),
        .sum_next (sum_next),
        .warm     (warm)
    );

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        data_d    = data_q;
        count_d   = count_q;
        tap_d     = tap_q;
        ready_d   = 1'b1;
        in_rd_inc = 1'b0;
        out_w_inc = 1'b0;
        stall     = 1'b0;
        win_push  = 1'b0;
        win_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    win_clear = 1'b1;
                end else if (tap_eff != tap_q) begin
                    // New window length: restart the window before accepting any sample.
                    tap_d     = tap_eff;
                    win_clear = 1'b1;
                end else if (ready_q && enable && !in_empty) begin
                    in_rd_inc = 1'b1;
                    sample_d  = in_rd_data;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    win_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    win_push = 1'b1;
                    data_d   = bypass ? sample_q : DATA_W'(sum_next >> tap_q);
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (flush) begin
                    win_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (out_full) begin
                    stall = 1'b1;
                end else begin
                    out_w_inc = 1'b1;
                    count_d   = count_q + CNT_W'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ready_q keeps the pop strobe low while reset is asserted and for the first edge after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sample_q <= '0;
            data_q   <= '0;
            count_q  <= '0;
            tap_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            data_q   <= data_d;
            count_q  <= count_d;
            tap_q    <= tap_d;
            ready_q  <= ready_d;
        end
    end

    assign out_w_data = data_q;
    assign out_count  = count_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dsp_mavg_stream.sv
// Directed bench for dsp_mavg_stream with hand-computed expected results.
module tb_dsp_mavg_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        bypass;
    logic        flush;
    logic [1:0]  tap_log2;
    logic        in_empty;
    logic [7:0]  in_rd_data;
    logic        in_rd_inc;
    logic        out_full;
    logic [7:0]  out_w_data;
    logic        out_w_inc;
    logic        busy;
    logic        stall;
    logic        warm;
    logic [15:0] out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsp_mavg_stream dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bypass     (bypass),
        .flush      (flush),
        .tap_log2   (tap_log2),
        .in_empty   (in_empty),
        .in_rd_data (in_rd_data),
        .in_rd_inc  (in_rd_inc),
        .out_full   (out_full),
        .out_w_data (out_w_data),
        .out_w_inc  (out_w_inc),
        .busy       (busy),
        .stall      (stall),
        .warm       (warm),
        .out_count  (out_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // Present a sample at the FIFO head and return just after the edge that pops it.
    task automatic wait_pop(input string tag, input logic [7:0] d);
        bit ok;
        ok         = 1'b0;
        in_rd_data = d;
        in_empty   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_rd_inc) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_pop"}, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_empty = 1'b1;
    endtask

    task automatic send(input string tag, input logic [7:0] d, input logic [7:0] exp,
                        input logic exp_warm);
        bit ok;
        int lat;
        wait_pop(tag, d);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (out_w_inc) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_data"}, 32'(out_w_data), 32'(exp));
        check({tag, "_warm"}, 32'(warm), 32'(exp_warm));
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t2_in  [5] = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd20};
    logic [7:0] t2_exp [5] = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd14};
    logic       t2_wrm [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] t3_exp [8] = '{8'd31, 8'd63, 8'd95, 8'd127, 8'd159, 8'd191, 8'd223, 8'd255};

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hold;
        rst        = 1'b0;
        enable     = 1'b0;
        bypass     = 1'b0;
        flush      = 1'b0;
        tap_log2   = 2'd2;
        in_empty   = 1'b1;
        in_rd_data = 8'd0;
        out_full   = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_rd_inc", 32'(in_rd_inc), 32'd0);
        check("rst_w_inc", 32'(out_w_inc), 32'd0);
        check("rst_w_data", 32'(out_w_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_warm", 32'(warm), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b1;

        for (int i = 0; i < 5; i++) begin
            send($sformatf("t2_%0d", i), t2_in[i], t2_exp[i], t2_wrm[i]);
        end
        check("t2_count", 32'(out_count), 32'd5);

        tap_log2 = 2'd3;
        for (int i = 0; i < 8; i++) begin
            send($sformatf("t3_%0d", i), 8'd255, t3_exp[i], (i == 7));
        end
        check("t3_count", 32'(out_count), 32'd13);

        // Back-pressure: result 0 enters the full 255 window -> 1785 >> 3 = 223.
        out_full = 1'b1;
        wait_pop("st", 8'd0);
        @(negedge clk);
        @(negedge clk);
        hold       = out_w_data;
        check("st_hold", 32'(hold), 32'd223);
        in_rd_data = 8'd77;
        in_empty   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("st_stall_%0d", i), 32'(stall), 32'd1);
            check($sformatf("st_winc_%0d", i), 32'(out_w_inc), 32'd0);
            check($sformatf("st_pop_%0d", i), 32'(in_rd_inc), 32'd0);
            check($sformatf("st_data_%0d", i), 32'(out_w_data), 32'(hold));
        end
        @(negedge clk);
        out_full = 1'b0;
        in_empty = 1'b1;
        #1;
        check("st_release_winc", 32'(out_w_inc), 32'd1);
        @(posedge clk);
        #1;
        check("st_count", 32'(out_count), 32'd14);
        check("st_after_winc", 32'(out_w_inc), 32'd0);

        tap_log2 = 2'd1;
        bypass   = 1'b1;
        send("byp_7", 8'd7, 8'd7, 1'b0);
        send("byp_9", 8'd9, 8'd9, 1'b1);
        bypass = 1'b0;
        send("avg_11", 8'd11, 8'd10, 1'b1);
        check("byp_count", 32'(out_count), 32'd17);

        wait_pop("fl", 8'd50);
        @(negedge clk);
        @(negedge clk);
        check("fl_busy_write", 32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        check("fl_no_push", 32'(out_w_inc), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_count", 32'(out_count), 32'd17);
        check("fl_winc", 32'(out_w_inc), 32'd0);
        send("fl_t1", 8'd8, 8'd4, 1'b0);
        tap_log2 = 2'd2;
        send("fl_t2a", 8'd8, 8'd2, 1'b0);
        send("fl_t2b", 8'd8, 8'd4, 1'b0);
        check("fl_count2", 32'(out_count), 32'd20);

        wait_pop("rs", 8'd100);
        #2;
        rst = 1'b0;
        #1;
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_w_data", 32'(out_w_data), 32'd0);
        check("rs_count", 32'(out_count), 32'd0);
        check("rs_rd_inc", 32'(in_rd_inc), 32'd0);
        check("rs_w_inc", 32'(out_w_inc), 32'd0);
        check("rs_warm", 32'(warm), 32'd0);
        @(negedge clk);
        enable     = 1'b0;
        in_empty   = 1'b0;
        in_rd_data = 8'd100;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rs_idle_no_pop", 32'(in_rd_inc), 32'd0);
        @(negedge clk);
        enable = 1'b1;
        #1;
        check("rs_pop_on_en", 32'(in_rd_inc), 32'd1);
        send("rs_after", 8'd100, 8'd25, 1'b0);
        check("rs_count_after", 32'(out_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
